// File: rtl/quartet_run_if.sv
// Host-side start/done handshake and run status for one quartet run controller.
interface quartet_run_if #(
  parameter int unsigned CountWidth = 32
) ();
  logic                  start_valid;
  logic                  start_ready;
  logic                  start_with_reset;
  logic [CountWidth-1:0] timeout_limit;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic [1:0]            status;
  logic [CountWidth-1:0] cycle_count;

  // Host side: requests runs and observes results.
  modport master (
    output start_valid, start_with_reset, timeout_limit, abort,
    input  start_ready, busy, done, status, cycle_count
  );

  // Controller side.
  modport slave (
    input  start_valid, start_with_reset, timeout_limit, abort,
    output start_ready, busy, done, status, cycle_count
  );
endinterface

// File: rtl/quartet_run_controller.sv
// Sequences one quartet program run: optional reset, settle, execute, completion detection.
// All outputs are registered; the host sees the result through a start/done handshake.
module quartet_run_controller #(
  parameter int unsigned ResetCycles   = 4,
  parameter int unsigned StatusLatency = 3,
  parameter int unsigned QuiesceCycles = 2,
  parameter int unsigned CountWidth    = 32
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  quartet_run_if.slave host,
  output logic        quartet_reset_o,
  output logic        quartet_enable_o,
  output logic        quartet_execute_o,
  input  logic        halted_i,
  input  logic        channels_quiescent_i,
  input  logic        routers_quiescent_i
);

  localparam int unsigned PhaseW = $clog2(ResetCycles + 1);
  localparam int unsigned QualW  = $clog2(QuiesceCycles + 1);

  localparam logic [1:0] StatNone     = 2'b00;
  localparam logic [1:0] StatFinished = 2'b01;
  localparam logic [1:0] StatTimeout  = 2'b10;
  localparam logic [1:0] StatAborted  = 2'b11;

  typedef enum logic [2:0] {StIdle, StRst, StSettle, StRun, StDone} state_e;

  state_e                state_q;
  logic                  q_reset_q, q_enable_q, q_execute_q;
  logic                  busy_q, done_q, start_ready_q;
  logic [1:0]            status_q;
  logic [CountWidth-1:0] cycle_count_q, limit_q;
  logic [PhaseW-1:0]     phase_q;
  logic [QualW-1:0]      qual_q;

  logic finish, qual_hit, timeout_hit;

  // Completion conditions for the current RUN cycle; status is untrusted until the
  // quartet's buffered outputs have caught up.
  always_comb begin
    finish      = halted_i && channels_quiescent_i && routers_quiescent_i &&
                  (cycle_count_q >= CountWidth'(StatusLatency));
    qual_hit    = finish && (qual_q == QualW'(QuiesceCycles - 1));
    timeout_hit = (limit_q != '0) && (cycle_count_q == limit_q);
  end

  // Run-sequencing FSM with registered outputs.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= StIdle;
      q_reset_q     <= 1'b1;
      q_enable_q    <= 1'b0;
      q_execute_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      start_ready_q <= 1'b0;
      status_q      <= StatNone;
      cycle_count_q <= '0;
      limit_q       <= '0;
      phase_q       <= '0;
      qual_q        <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          q_reset_q     <= 1'b0;
          q_enable_q    <= 1'b1;
          q_execute_q   <= 1'b0;
          start_ready_q <= 1'b1;
          if (host.start_valid && start_ready_q) begin
            limit_q       <= host.timeout_limit;
            cycle_count_q <= '0;
            status_q      <= StatNone;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            phase_q       <= '0;
            qual_q        <= '0;
            if (host.start_with_reset) begin
              state_q    <= StRst;
              q_reset_q  <= 1'b1;
              q_enable_q <= 1'b0;
            end else begin
              state_q <= StSettle;
            end
          end
        end
        StRst: begin
          if (host.abort) begin
            state_q    <= StDone;
            q_reset_q  <= 1'b0;
            q_enable_q <= 1'b1;
            status_q   <= StatAborted;
            done_q     <= 1'b1;
          end else if (phase_q == PhaseW'(ResetCycles - 1)) begin
            state_q    <= StSettle;
            q_reset_q  <= 1'b0;
            q_enable_q <= 1'b1;
            phase_q    <= '0;
          end else begin
            phase_q <= phase_q + PhaseW'(1);
          end
        end
        // Two cycles so the quartet's buffered reset/enable have landed before execute.
        StSettle: begin
          if (host.abort) begin
            state_q  <= StDone;
            status_q <= StatAborted;
            done_q   <= 1'b1;
          end else if (phase_q == PhaseW'(1)) begin
            state_q     <= StRun;
            q_execute_q <= 1'b1;
            qual_q      <= '0;
          end else begin
            phase_q <= phase_q + PhaseW'(1);
          end
        end
        // Exit priority: qualified finish, then abort, then timeout.
        StRun: begin
          if (qual_hit || host.abort || timeout_hit) begin
            state_q     <= StDone;
            q_execute_q <= 1'b0;
            done_q      <= 1'b1;
            if (qual_hit)        status_q <= StatFinished;
            else if (host.abort) status_q <= StatAborted;
            else                 status_q <= StatTimeout;
          end else begin
            if (cycle_count_q != '1) cycle_count_q <= cycle_count_q + CountWidth'(1);
            qual_q <= finish ? qual_q + QualW'(1) : '0;
          end
        end
        StDone: begin
          state_q       <= StIdle;
          busy_q        <= 1'b0;
          start_ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign quartet_reset_o   = q_reset_q;
  assign quartet_enable_o  = q_enable_q;
  assign quartet_execute_o = q_execute_q;
  assign host.start_ready  = start_ready_q;
  assign host.busy         = busy_q;
  assign host.done         = done_q;
  assign host.status       = status_q;
  assign host.cycle_count  = cycle_count_q;

endmodule
